// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone initiator.
// A command (read or write) is accepted on cmd_valid && cmd_ready, driven onto
// the Wishbone bus until wb_ack or a wait-cycle timeout, and its result is then
// held on the rsp_* port until rsp_ready.
//
// Ports:
//   clk_wb, rst_wb_a            - clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         - command handshake
//   cmd_addr/wdata/wstb/we      - command fields (we=1 write, we=0 read)
//   rsp_valid/rsp_ready         - response handshake
//   rsp_rdata/rsp_err           - read data (0 for writes), timeout error flag
//   wb_addr/wdata/wstb/we/re    - registered Wishbone request fields
//   wb_cyc/wb_stb               - registered Wishbone cycle qualifiers
//   wb_rdata/wb_ack             - Wishbone slave return path
//   busy                        - high whenever the FSM is not idle
//
// Parameter TIMEOUT: max wait cycles for wb_ack, 0 disables the timeout.
module wb_initiator #(
  parameter logic [15:0] TIMEOUT = 16'd255
) (
  input  logic        clk_wb,
  input  logic        rst_wb_a,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [16:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstb,
  input  logic        cmd_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [16:0] wb_addr,
  output logic [31:0] wb_wdata,
  output logic [3:0]  wb_wstb,
  output logic        wb_we,
  output logic        wb_re,
  output logic        wb_cyc,
  output logic        wb_stb,
  input  logic [31:0] wb_rdata,
  input  logic        wb_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RSP
  } state_t;

  state_t      state;
  logic [15:0] wait_cnt;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk_wb or posedge rst_wb_a) begin
    if (rst_wb_a) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wb_addr   <= '0;
      wb_wdata  <= '0;
      wb_wstb   <= '0;
      wb_we     <= 1'b0;
      wb_re     <= 1'b0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_addr  <= cmd_addr;
            wb_wdata <= cmd_wdata;
            wb_we    <= cmd_we;
            wb_re    <= ~cmd_we;
            wb_wstb  <= cmd_we ? cmd_wstb : 4'hF;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
            wait_cnt <= '0;
            state    <= BUS;
          end
        end

        BUS: begin
          // Ack is checked first so that an ack coinciding with the timeout
          // cycle completes normally.
          if (wb_ack) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_re     <= 1'b0;
            wb_we     <= 1'b0;
            rsp_rdata <= wb_re ? wb_rdata : '0;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else if ((TIMEOUT != 16'd0) && (wait_cnt == TIMEOUT)) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_re     <= 1'b0;
            wb_we     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed testbench for wb_initiator (TIMEOUT overridden to 4).
// Inputs are driven and outputs sampled on the falling edge of clk_wb.
module tb_wb_initiator;

  logic        clk_wb;
  logic        rst_wb_a;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [16:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstb;
  logic        cmd_we;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [16:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wstb;
  logic        wb_we;
  logic        wb_re;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        busy;

  int errors = 0;
  int checks = 0;

  wb_initiator #(.TIMEOUT(16'd4)) dut (
    .clk_wb    (clk_wb),
    .rst_wb_a  (rst_wb_a),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_wstb  (cmd_wstb),
    .cmd_we    (cmd_we),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_addr   (wb_addr),
    .wb_wdata  (wb_wdata),
    .wb_wstb   (wb_wstb),
    .wb_we     (wb_we),
    .wb_re     (wb_re),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_rdata  (wb_rdata),
    .wb_ack    (wb_ack),
    .busy      (busy)
  );

  initial begin
    clk_wb = 1'b0;
    forever #5 clk_wb = ~clk_wb;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_wb_a  = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wstb  = '0;
    cmd_we    = 1'b0;
    rsp_ready = 1'b0;
    wb_rdata  = 32'hFFFF_FFFF;
    wb_ack    = 1'b0;
    repeat (3) @(negedge clk_wb);
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_re, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: cyc/stb/we/re/busy=%b required 00000", {wb_cyc, wb_stb, wb_we, wb_re, busy});
    end
    checks++;
    if ({wb_addr, wb_wdata, wb_wstb} !== 53'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h wstb=%h required 0", wb_addr, wb_wdata, wb_wstb);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 0", rsp_valid, rsp_err, rsp_rdata);
    end
    rst_wb_a = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  // Write, ack on the 4th bus cycle.
  task automatic test_write();
    @(negedge clk_wb);
    cmd_valid = 1'b1;
    cmd_addr  = 17'h00104;
    cmd_wdata = 32'hCAFEF00D;
    cmd_wstb  = 4'b0011;
    cmd_we    = 1'b1;
    wb_rdata  = 32'hDEADBEEF;
    @(negedge clk_wb);
    cmd_valid = 1'b0;
    checks++;
    if ({wb_addr, wb_wdata, wb_wstb, wb_we, wb_re} !== {17'h00104, 32'hCAFEF00D, 4'b0011, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL write_fields: addr=%h wdata=%h wstb=%b we=%b re=%b required 00104 cafef00d 0011 1 0",
               wb_addr, wb_wdata, wb_wstb, wb_we, wb_re);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wb_cyc, wb_stb, busy, cmd_ready, rsp_valid} !== 5'b11100) begin
        errors++;
        $display("FAIL write_bus_cycle%0d: cyc/stb/busy/ready/rspv=%b required 11100", i,
                 {wb_cyc, wb_stb, busy, cmd_ready, rsp_valid});
      end
      wb_ack = (i == 3);
      @(negedge clk_wb);
    end
    wb_ack = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, wb_re} !== 4'b0) begin
      errors++;
      $display("FAIL write_release: cyc/stb/we/re=%b required 0000", {wb_cyc, wb_stb, wb_we, wb_re});
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL write_rsp: valid=%b err=%b rdata=%h required 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(negedge clk_wb);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL write_done: rspv/ready/busy=%b required 010", {rsp_valid, cmd_ready, busy});
    end
  endtask

  // Read acked on its first bus cycle, with a second read presented during
  // BUS; with rsp_ready high it must be accepted exactly at edge N+3.
  task automatic test_read_roundtrip();
    rsp_ready = 1'b1;
    @(negedge clk_wb);
    cmd_valid = 1'b1;
    cmd_addr  = 17'h1FFFC;
    cmd_wdata = 32'h11111111;
    cmd_wstb  = 4'b0000;
    cmd_we    = 1'b0;
    @(negedge clk_wb);                       // after edge N
    checks++;
    if ({wb_addr, wb_wstb, wb_re, wb_we, wb_cyc, cmd_ready} !== {17'h1FFFC, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL read_fields: addr=%h wstb=%h re=%b we=%b cyc=%b ready=%b required 1fffc f 1 0 1 0",
               wb_addr, wb_wstb, wb_re, wb_we, wb_cyc, cmd_ready);
    end
    cmd_addr  = 17'h00ABC;
    cmd_wstb  = 4'b1010;
    wb_ack    = 1'b1;
    wb_rdata  = 32'h12345678;
    @(negedge clk_wb);                       // after edge N+1
    wb_ack   = 1'b0;
    wb_rdata = 32'h0BADF00D;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, wb_cyc, cmd_ready} !== {1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL read_rsp: valid=%b err=%b rdata=%h cyc=%b ready=%b required 1 0 12345678 0 0",
               rsp_valid, rsp_err, rsp_rdata, wb_cyc, cmd_ready);
    end
    @(negedge clk_wb);                       // after edge N+2
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc} !== 3'b010) begin
      errors++;
      $display("FAIL read_return_idle: rspv/ready/cyc=%b required 010", {rsp_valid, cmd_ready, wb_cyc});
    end
    @(negedge clk_wb);                       // after edge N+3
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc, wb_addr, wb_wstb, wb_re} !== {1'b1, 17'h00ABC, 4'hF, 1'b1}) begin
      errors++;
      $display("FAIL read_second_accept: cyc=%b addr=%h wstb=%h re=%b required 1 00abc f 1",
               wb_cyc, wb_addr, wb_wstb, wb_re);
    end
    wb_ack = 1'b1;
    @(negedge clk_wb);
    wb_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL read_second_rsp: valid=%b rdata=%h required 1 0badf00d", rsp_valid, rsp_rdata);
    end
    @(negedge clk_wb);
    rsp_ready = 1'b0;
  endtask

  // No ack: 5 bus cycles (counter 0..4), then an error response.
  // Second pass: ack on the counter==4 cycle wins over the timeout.
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk_wb);
      cmd_valid = 1'b1;
      cmd_addr  = 17'h00200;
      cmd_we    = 1'b0;
      wb_rdata  = 32'h55AA55AA;
      @(negedge clk_wb);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if ({wb_cyc, rsp_valid} !== 2'b10) begin
          errors++;
          $display("FAIL timeout_p%0d_cycle%0d: cyc/rspv=%b required 10", pass, i, {wb_cyc, rsp_valid});
        end
        wb_ack = (pass == 1) && (i == 4);
        @(negedge clk_wb);
      end
      wb_ack = 1'b0;
      if (pass == 0) begin
        checks++;
        if ({wb_cyc, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
          errors++;
          $display("FAIL timeout_err: cyc=%b valid=%b err=%b rdata=%h required 0 1 1 00000000",
                   wb_cyc, rsp_valid, rsp_err, rsp_rdata);
        end
      end else begin
        checks++;
        if ({wb_cyc, rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 32'h55AA55AA}) begin
          errors++;
          $display("FAIL timeout_ack_wins: cyc=%b valid=%b err=%b rdata=%h required 0 1 0 55aa55aa",
                   wb_cyc, rsp_valid, rsp_err, rsp_rdata);
        end
      end
      rsp_ready = 1'b1;
      @(negedge clk_wb);
      rsp_ready = 1'b0;
    end
  endtask

  // Response held 10 cycles with a second command waiting.
  task automatic test_backpressure();
    @(negedge clk_wb);
    cmd_valid = 1'b1;
    cmd_addr  = 17'h00010;
    cmd_we    = 1'b0;
    wb_rdata  = 32'hA5A50001;
    @(negedge clk_wb);
    cmd_addr  = 17'h00020;
    cmd_wdata = 32'h87654321;
    cmd_wstb  = 4'b1100;
    cmd_we    = 1'b1;
    wb_ack    = 1'b1;
    @(negedge clk_wb);
    wb_ack   = 1'b0;
    wb_rdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, busy, wb_cyc} !==
          {1'b1, 1'b0, 32'hA5A50001, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b err=%b rdata=%h ready=%b busy=%b cyc=%b required 1 0 a5a50001 0 1 0",
                 i, rsp_valid, rsp_err, rsp_rdata, cmd_ready, busy, wb_cyc);
      end
      @(negedge clk_wb);
    end
    rsp_ready = 1'b1;
    @(negedge clk_wb);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, wb_cyc} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: rspv/ready/cyc=%b required 010", {rsp_valid, cmd_ready, wb_cyc});
    end
    @(negedge clk_wb);
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc, wb_addr, wb_wdata, wb_wstb, wb_we} !== {1'b1, 17'h00020, 32'h87654321, 4'b1100, 1'b1}) begin
      errors++;
      $display("FAIL bp_second_accept: cyc=%b addr=%h wdata=%h wstb=%b we=%b required 1 00020 87654321 1100 1",
               wb_cyc, wb_addr, wb_wdata, wb_wstb, wb_we);
    end
    wb_ack = 1'b1;
    @(negedge clk_wb);
    wb_ack    = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk_wb);
    rsp_ready = 1'b0;
  endtask

  // Stray acks in IDLE and RSP must change nothing.
  task automatic test_stray_ack();
    // Idle; last response was a write, so rsp_rdata is 0.
    wb_rdata = 32'hFEEDFACE;
    wb_ack   = 1'b1;
    @(negedge clk_wb);
    wb_ack = 1'b0;
    checks++;
    if ({busy, cmd_ready, wb_cyc, rsp_valid, rsp_rdata} !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL stray_idle: busy=%b ready=%b cyc=%b rspv=%b rdata=%h required 0 1 0 0 00000000",
               busy, cmd_ready, wb_cyc, rsp_valid, rsp_rdata);
    end
    cmd_valid = 1'b1;
    cmd_addr  = 17'h00300;
    cmd_we    = 1'b0;
    wb_rdata  = 32'h00C0FFEE;
    @(negedge clk_wb);
    cmd_valid = 1'b0;
    wb_ack    = 1'b1;
    @(negedge clk_wb);
    wb_ack   = 1'b0;
    wb_rdata = 32'h99999999;
    @(negedge clk_wb);
    wb_ack = 1'b1;                           // stray ack while in RSP
    @(negedge clk_wb);
    wb_ack = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, busy, wb_cyc} !== {1'b1, 1'b0, 32'h00C0FFEE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stray_rsp: valid=%b err=%b rdata=%h busy=%b cyc=%b required 1 0 00c0ffee 1 0",
               rsp_valid, rsp_err, rsp_rdata, busy, wb_cyc);
    end
    rsp_ready = 1'b1;
    @(negedge clk_wb);
    rsp_ready = 1'b0;
  endtask

  // Reset asserted on wait cycle 2 aborts the transfer immediately.
  task automatic test_reset_mid_bus();
    cmd_valid = 1'b1;
    cmd_addr  = 17'h00400;
    cmd_wdata = 32'h13579BDF;
    cmd_wstb  = 4'b1111;
    cmd_we    = 1'b1;
    @(negedge clk_wb);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk_wb);            // now in wait cycle 2
    checks++;
    if (wb_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_precheck: cyc=%b required 1", wb_cyc);
    end
    rsp_ready = 1'b1;
    rst_wb_a  = 1'b1;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, busy, wb_addr} !== {1'b0, 1'b0, 1'b0, 1'b0, 17'h0}) begin
      errors++;
      $display("FAIL rst_mid_async: cyc=%b stb=%b we=%b busy=%b addr=%h required 0 0 0 0 00000",
               wb_cyc, wb_stb, wb_we, busy, wb_addr);
    end
    @(negedge clk_wb);
    rst_wb_a  = 1'b0;
    rsp_ready = 1'b0;
    wb_ack    = 1'b1;                        // late ack must be ignored
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: cmd_ready=%b required 1", cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_wb);
      wb_ack = 1'b0;
      checks++;
      if ({rsp_valid, wb_cyc, busy} !== 3'b000) begin
        errors++;
        $display("FAIL rst_mid_no_rsp%0d: rspv/cyc/busy=%b required 000", i, {rsp_valid, wb_cyc, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_roundtrip();
    test_timeout();
    test_backpressure();
    test_stray_ack();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
